// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package: hazard FSM encoding and scoreboard entry.
// Used by hazard_ctrl and sb_fifo.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hc_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       rwen;
    logic       is_load;
  } sb_entry_t;

  // True when a used, non-x0 source reads the entry's destination.
  function automatic logic src_hit(
    input logic       use_i,
    input logic [4:0] rs,
    input sb_entry_t  e
  );
    return use_i && (rs != 5'd0) && e.rwen && (e.rd == rs);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order scoreboard FIFO exposing every slot, a per-slot valid
// mask and the index of the youngest entry.
module sb_fifo
  import hazard_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  sb_entry_t             push_data,
  input  logic                  pop,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic [AW-1:0]         youngest,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  sb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic do_push, do_pop;
  logic [AW-1:0] off;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign entries  = mem_q;
  assign count    = cnt_q;
  assign youngest = wr_q - AW'(1);

  // Next pointers, count and storage.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is live when its distance from the head is below count.
  always_comb begin
    off   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = AW'(i) - rd_q;
      valid[i] = ({1'b0, off} < cnt_q);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; stale slots are masked by valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard control: RAW scoreboard, stall/flush FSM and
// perf counters. Define HAZARD_CTRL_FWD_EN for load-use-only stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [4:0]       id_rd,
  input  logic             id_rwen,
  input  logic             id_is_load,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic             redirect,
  output logic             pipe_stop,
  output logic             inst_clear,
  output logic             issue,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int AW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t             push_data;
  logic [DEPTH-1:0]      valid;
  logic [AW-1:0]         youngest;
  logic [AW:0]           count;
  logic                  full, empty;
  logic                  pop, hazard, blk;

  hc_state_e        state_q, state_d;
  logic             init_q, init_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  assign blk          = rst | init_q;
  assign pop          = wb_valid & ~rst;
  assign busy         = busy_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

  assign push_data = '{
    rd:      id_rd,
    rwen:    id_rwen & (id_rd != 5'd0),
    is_load: id_is_load
  };

  sb_fifo #(.DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (push_data),
    .pop       (pop),
    .entries   (entries),
    .valid     (valid),
    .youngest  (youngest),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef HAZARD_CTRL_FWD_EN
  logic unused_valid;
  assign unused_valid = ^valid;

  // Forwarding covers all but a load feeding the next instruction.
  always_comb begin
    hazard = 1'b0;
    if (!empty && entries[youngest].is_load) begin
      hazard = src_hit(id_rs1_use, id_rs1, entries[youngest])
             | src_hit(id_rs2_use, id_rs2, entries[youngest]);
    end
  end
`else
  logic unused_fwd;

  // No forwarding: any pending writer of a source blocks decode.
  always_comb begin
    hazard     = 1'b0;
    unused_fwd = ^youngest;
    for (int i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ entries[i].is_load;
      if (valid[i]) begin
        hazard = hazard
               | src_hit(id_rs1_use, id_rs1, entries[i])
               | src_hit(id_rs2_use, id_rs2, entries[i]);
      end
    end
  end
`endif

  // FSM next state and decode-stage controls.
  always_comb begin
    state_d    = state_q;
    pipe_stop  = 1'b0;
    inst_clear = 1'b0;
    issue      = 1'b0;
    if (!blk) begin
      unique case (state_q)
        RUN, STALL: begin
          if (redirect) begin
            state_d    = FLUSH;
            inst_clear = 1'b1;
          end else begin
            pipe_stop = id_valid & (hazard | full);
            state_d   = pipe_stop ? STALL : RUN;
            issue     = id_valid & ex_ready & ~pipe_stop;
          end
        end
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating counters, post-reset blanking and busy flag.
  always_comb begin
    init_d  = 1'b0;
    stall_d = stall_q;
    flush_d = flush_q;
    if (pipe_stop && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if ((state_d == FLUSH) && (state_q != FLUSH)
        && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
    case ({issue, pop & ~empty})
      2'b10:   busy_d = 1'b1;
      2'b01:   busy_d = (count != (AW+1)'(1));
      default: busy_d = ~empty;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      init_q  <= 1'b1;
      busy_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule
